sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-master, one-slave arbiter for the core's SRAM-like memory interface. It merges the fetch-stage instruction port and the EXE/MEM data port onto a single SRAM-like slave port (the bridge towards AXI). It tracks accepted-but-unanswered transactions in an in-order ID FIFO, so each `data_ok`/`rdata` response is steered back to the master that issued it. Data requests take priority over instruction requests; once a request is presented to the slave, its grant is locked until address handshake.

## Interface
- `DEPTH`, 4: max outstanding transactions; power of two, at least 2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `inst_req`, `inst_wr` in 1 each: instruction master request / write flag.
- `inst_size` in 2, `inst_wstrb` in 4, `inst_addr` in 32, `inst_wdata` in 32: instruction request payload.
- `inst_addr_ok`, `inst_data_ok` out 1 each: instruction address accepted / response valid.
- `inst_rdata` out 32: instruction response data.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata` in 1/1/2/4/32/32: data master request and payload.
- `data_addr_ok`, `data_data_ok` out 1 each: data address accepted / response valid.
- `data_rdata` out 32: data response data.
- `mem_req`, `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata` out 1/1/2/4/32/32: request to slave.
- `mem_addr_ok`, `mem_data_ok` in 1 each: slave address / response handshakes.
- `mem_rdata` in 32: slave response data.
- `outstanding` out log2(DEPTH)+1: current FIFO occupancy.
- `proto_err` out 1: sticky flag, set on a response with no outstanding transaction.

## Operation
- Masters hold `req` and payload stable from assertion until `addr_ok`. Writes also receive a `data_ok`.
- Source select `sel` (0 = inst, 1 = data):
  - If `lock_v` is set: `sel = lock_src`.
  - Else if `data_req`: `sel = 1`.
  - Else: `sel = 0`.
- `mem_req = (sel ? data_req : inst_req) && !full`, where `full = (outstanding == DEPTH)`.
- Payload muxed to `mem_*` by `sel`. Payload is don't-care when `mem_req = 0`.
- `inst_addr_ok = mem_addr_ok && mem_req && !sel`; `data_addr_ok = mem_addr_ok && mem_req && sel`.
- Grant lock:
  - Set `lock_v` and `lock_src <= sel` when `mem_req && !mem_addr_ok`.
  - Clear `lock_v` when `mem_req && mem_addr_ok`.
  - A data request arriving while an inst request is locked waits.
- ID FIFO, `DEPTH` entries of 1 bit, rd/wr pointers with wrap-around:
  - Push `sel` on `mem_req && mem_addr_ok`.
  - Pop on `mem_data_ok && !empty`.
- Response routing, with `head` = FIFO head ID:
  - `inst_data_ok = mem_data_ok && !empty && !head`.
  - `data_data_ok = mem_data_ok && !empty && head`.
  - `inst_rdata = data_rdata = mem_rdata`.
- `outstanding`: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full: `mem_req` forced 0, so no push. A pop in the same cycle frees one entry for the next cycle.
- Empty: `mem_data_ok` is ignored (no master sees it) and `proto_err <= 1`.
- Reset mid-operation: pointers, count, lock and `proto_err` are cleared. The slave is reset by the same `reset`, so no stale responses are expected.

## Timing
- Reset values: `outstanding = 0`, `proto_err = 0`, `lock_v = 0`.
- With all inputs low, every output is 0.
- Request path is combinational: master `req` appears on `mem_req` in the same cycle, and `mem_addr_ok` appears on the granted `addr_ok` in the same cycle.
- Response path is combinational: `mem_data_ok` and `mem_rdata` reach the master in the same cycle.
- Zero added latency. Back-to-back accepted requests are allowed every cycle until full.
- The FIFO head updates on the clock edge after a pop. A push and a pop in the same cycle into an empty FIFO is not possible: the response comes at least one cycle after its address handshake.

## Test plan
- Single inst read:
  - Stimulus: `inst_req = 1`, addr `0x1C000000`; `mem_addr_ok` in cycle 0; `mem_data_ok` in cycle 2 with rdata `0x02800C0C`.
  - Required: `inst_addr_ok` in cycle 0, `inst_data_ok` and `inst_rdata = 0x02800C0C` in cycle 2, `outstanding` goes 0→1→0.
- Priority and lock:
  - Stimulus, case A: both `req` high, `mem_addr_ok = 0` for 3 cycles. Case B: `inst_req` alone, then `data_req` rises in cycle 1 while inst is stalled.
  - Required, case A: data granted and held all 3 cycles. Case B: inst stays granted until its `addr_ok`, and data is issued the cycle after.
- Interleaved ordering:
  - Stimulus: accept inst@`0x100`, data@`0x200`, inst@`0x104`; return rdata `0xA`, `0xB`, `0xC` on consecutive cycles.
  - Required: `inst_data_ok` with `0xA`, then `data_data_ok` with `0xB`, then `inst_data_ok` with `0xC`.
- Full:
  - Stimulus: `DEPTH` (4) accepted requests with no responses, then a 5th request.
  - Required: `mem_req = 0` for the 5th. After one `mem_data_ok`, `mem_req` reasserts the next cycle and pointers wrap correctly.
- Spurious response:
  - Stimulus: `mem_data_ok = 1` while `outstanding = 0`.
  - Required: no master `data_ok`, `proto_err = 1` from the next cycle and held until `reset`.
- Reset mid-flight:
  - Stimulus: `outstanding = 3`, `lock_v = 1`, then `reset` pulses.
  - Required: `outstanding = 0`, `lock_v = 0`, `proto_err = 0` after the edge, and a new data request is granted immediately.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like bus bundle: request/payload from the issuing side, address and
// data handshakes plus read data from the answering side.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Issuing side (a pipeline master, or the arbiter towards the slave).
  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Answering side (the slave, or the arbiter towards each master).
  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master / one-slave SRAM-like bus arbiter. Data port has priority over
// the instruction port; a presented request keeps its grant until its address
// handshake. An in-order 1-bit ID FIFO steers each response back to its master.
module sram_bus_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_bus_arbiter_if.slave      inst,
  sram_bus_arbiter_if.slave      data,
  sram_bus_arbiter_if.master     mem,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   proto_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic             sel;
  logic             lock_v;
  logic             lock_src;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head;
  logic [DEPTH-1:0] id_fifo;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (outstanding == CNT_FULL);
  assign empty = (outstanding == '0);

  // Source select: a locked grant wins, otherwise data beats instruction.
  always_comb begin
    sel = SRC_INST;
    if (lock_v) begin
      sel = lock_src;
    end else if (data.req) begin
      sel = SRC_DATA;
    end
  end

  // Request path to the slave; no new request is issued while the FIFO is full.
  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = inst.wr;
    mem.size  = inst.size;
    mem.wstrb = inst.wstrb;
    mem.addr  = inst.addr;
    mem.wdata = inst.wdata;
    if (sel == SRC_DATA) begin
      mem.req   = data.req && !full;
      mem.wr    = data.wr;
      mem.size  = data.size;
      mem.wstrb = data.wstrb;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else begin
      mem.req   = inst.req && !full;
    end
  end

  assign push = mem.req && mem.addr_ok;
  assign pop  = mem.data_ok && !empty;
  assign head = id_fifo[rd_ptr];

  // Address handshake goes only to the currently granted master.
  always_comb begin
    inst.addr_ok = push && (sel == SRC_INST);
    data.addr_ok = push && (sel == SRC_DATA);
  end

  // Response routing by the ID at the FIFO head; a response with nothing
  // outstanding reaches neither master.
  always_comb begin
    inst.data_ok = pop && (head == SRC_INST);
    data.data_ok = pop && (head == SRC_DATA);
    inst.rdata   = mem.rdata;
    data.rdata   = mem.rdata;
  end

  // Grant lock: held from the first stalled cycle until the address handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_v   <= 1'b0;
      lock_src <= SRC_INST;
    end else if (mem.req) begin
      if (mem.addr_ok) begin
        lock_v <= 1'b0;
      end else begin
        lock_v   <= 1'b1;
        lock_src <= sel;
      end
    end
  end

  // ID storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo[wr_ptr] <= sel;
    end
  end

  // FIFO pointers; DEPTH is a power of two so the natural overflow wraps them.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky protocol error on a response that has no outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (mem.data_ok && empty) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed plus randomized bench for sram_bus_arbiter against a queue-based
// transaction model.
module tb_sram_bus_arbiter;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [2:0] outstanding;
  logic       proto_err;

  sram_bus_arbiter_if inst_bus ();
  sram_bus_arbiter_if data_bus ();
  sram_bus_arbiter_if mem_bus ();

  sram_bus_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst_bus),
    .data        (data_bus),
    .mem         (mem_bus),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: queue of issuer IDs (0 = inst, 1 = data) in acceptance
  // order, the master currently holding a stalled grant, and the sticky error.
  bit mq[$];
  bit pend_v;
  bit pend_src;
  bit m_proto;
  bit last_iacc, last_dacc;

  // Snapshot of DUT outputs from the most recent cycle.
  logic        s_mreq, s_iaok, s_daok, s_idok, s_ddok, s_proto;
  logic [31:0] s_maddr, s_irdata, s_drdata, s_outst;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare every output against the model, then advance it.
  task automatic tick();
    bit src, full, mreq, acc, have, pop, head;
    @(negedge clk);
    src  = pend_v ? pend_src : data_bus.req;
    full = (mq.size() == DEPTH);
    mreq = (src ? data_bus.req : inst_bus.req) && !full;
    acc  = mreq && mem_bus.addr_ok;
    have = (mq.size() != 0);
    pop  = mem_bus.data_ok && have;
    head = have ? mq[0] : 1'b0;

    s_mreq   = mem_bus.req;
    s_maddr  = mem_bus.addr;
    s_iaok   = inst_bus.addr_ok;
    s_daok   = data_bus.addr_ok;
    s_idok   = inst_bus.data_ok;
    s_ddok   = data_bus.data_ok;
    s_irdata = inst_bus.rdata;
    s_drdata = data_bus.rdata;
    s_outst  = 32'(outstanding);
    s_proto  = proto_err;

    chk1("mem_req", s_mreq, mreq);
    if (mreq) begin
      chk32("mem_addr", s_maddr, src ? data_bus.addr : inst_bus.addr);
      chk32("mem_wdata", mem_bus.wdata, src ? data_bus.wdata : inst_bus.wdata);
      chk32("mem_ctl", {25'd0, mem_bus.wr, mem_bus.size, mem_bus.wstrb},
            src ? {25'd0, data_bus.wr, data_bus.size, data_bus.wstrb}
                : {25'd0, inst_bus.wr, inst_bus.size, inst_bus.wstrb});
    end
    chk1("inst_addr_ok", s_iaok, acc && !src);
    chk1("data_addr_ok", s_daok, acc && src);
    chk1("inst_data_ok", s_idok, pop && !head);
    chk1("data_data_ok", s_ddok, pop && head);
    if (pop) begin
      chk32("inst_rdata", s_irdata, mem_bus.rdata);
      chk32("data_rdata", s_drdata, mem_bus.rdata);
    end
    chk32("outstanding", s_outst, 32'(mq.size()));
    chk1("proto_err", s_proto, m_proto);

    last_iacc = acc && !src;
    last_dacc = acc && src;
    if (acc) pend_v = 1'b0;
    else if (mreq) begin
      pend_v   = 1'b1;
      pend_src = src;
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(src);
    if (mem_bus.data_ok && !have) m_proto = 1'b1;

    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'h0;
    inst_bus.addr = '0; inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2; data_bus.wstrb = 4'h0;
    data_bus.addr = '0; data_bus.wdata = '0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    pend_v  = 1'b0;
    m_proto = 1'b0;
  endtask

  // Return responses until the model has nothing outstanding, then confirm
  // the DUT count is back to zero.
  task automatic drain();
    inst_bus.req = 1'b0;
    data_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    for (int n = 0; n < 2 * DEPTH && mq.size() != 0; n++) begin
      mem_bus.data_ok = 1'b1;
      mem_bus.rdata   = $urandom;
      tick();
    end
    mem_bus.data_ok = 1'b0;
    tick();
    chk32("drain_outstanding", s_outst, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state, all inputs low: every output zero.
    tick();
    chk32("rst_outstanding", s_outst, 32'd0);
    chk1("rst_proto", s_proto, 1'b0);
    chk1("idle_mem_req", s_mreq, 1'b0);
    chk32("idle_maddr", s_maddr, 32'd0);

    // Single instruction read.
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000; mem_bus.addr_ok = 1'b1;
    tick();
    chk1("t1_iaok", s_iaok, 1'b1);
    chk32("t1_maddr", s_maddr, 32'h1C00_0000);
    chk32("t1_out0", s_outst, 32'd0);
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    tick();
    chk32("t1_out1", s_outst, 32'd1);
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0280_0C0C;
    tick();
    chk1("t1_idok", s_idok, 1'b1);
    chk1("t1_ddok", s_ddok, 1'b0);
    chk32("t1_rdata", s_irdata, 32'h0280_0C0C);
    mem_bus.data_ok = 1'b0;
    tick();
    chk32("t1_out_end", s_outst, 32'd0);

    // Priority: both request, slave stalls three cycles.
    inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_1000;
    data_bus.req = 1'b1; data_bus.addr = 32'h0000_2000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk32("t2a_maddr", s_maddr, 32'h0000_2000);
      chk1("t2a_daok", s_daok, 1'b0);
    end
    mem_bus.addr_ok = 1'b1;
    tick();
    chk1("t2a_daok_go", s_daok, 1'b1);
    chk1("t2a_iaok_no", s_iaok, 1'b0);
    data_bus.req = 1'b0;
    tick();
    chk1("t2a_iaok_next", s_iaok, 1'b1);
    drain();

    // Lock: inst stalled, data arrives, inst keeps the grant.
    inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_3000; mem_bus.addr_ok = 1'b0;
    tick();
    data_bus.req = 1'b1; data_bus.addr = 32'h0000_4000;
    tick();
    chk32("t2b_locked_addr", s_maddr, 32'h0000_3000);
    mem_bus.addr_ok = 1'b1;
    tick();
    chk1("t2b_iaok", s_iaok, 1'b1);
    chk1("t2b_daok_wait", s_daok, 1'b0);
    inst_bus.req = 1'b0;
    tick();
    chk1("t2b_daok", s_daok, 1'b1);
    chk32("t2b_data_addr", s_maddr, 32'h0000_4000);
    drain();

    // Interleaved ordering.
    mem_bus.addr_ok = 1'b1;
    inst_bus.req = 1'b1; inst_bus.addr = 32'h100;
    tick();
    inst_bus.req = 1'b0; data_bus.req = 1'b1; data_bus.addr = 32'h200;
    tick();
    data_bus.req = 1'b0; inst_bus.req = 1'b1; inst_bus.addr = 32'h104;
    tick();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    mem_bus.rdata = 32'hA;
    tick();
    chk1("t3_a_idok", s_idok, 1'b1);
    chk32("t3_a_rdata", s_irdata, 32'hA);
    mem_bus.rdata = 32'hB;
    tick();
    chk1("t3_b_ddok", s_ddok, 1'b1);
    chk1("t3_b_idok", s_idok, 1'b0);
    chk32("t3_b_rdata", s_drdata, 32'hB);
    mem_bus.rdata = 32'hC;
    tick();
    chk1("t3_c_idok", s_idok, 1'b1);
    chk32("t3_c_rdata", s_irdata, 32'hC);
    mem_bus.data_ok = 1'b0;
    tick();

    // Full: alternate sources to fill, then a fifth request, then wrap.
    mem_bus.addr_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      inst_bus.req = (i % 2 == 0); inst_bus.addr = 32'h300 + 32'(i);
      data_bus.req = (i % 2 == 1); data_bus.addr = 32'h400 + 32'(i);
      tick();
    end
    data_bus.req = 1'b0; inst_bus.req = 1'b1; inst_bus.addr = 32'h500;
    tick();
    chk1("t4_full_mreq", s_mreq, 1'b0);
    chk32("t4_full_out", s_outst, 32'd4);
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h55;
    tick();
    chk1("t4_pop_mreq", s_mreq, 1'b0);
    chk1("t4_pop_idok", s_idok, 1'b1);
    mem_bus.data_ok = 1'b0;
    tick();
    chk1("t4_reissue", s_mreq, 1'b1);
    chk1("t4_reissue_ok", s_iaok, 1'b1);
    chk32("t4_out3", s_outst, 32'd3);
    drain();

    // Spurious response.
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hDEAD;
    tick();
    chk1("t5_idok", s_idok, 1'b0);
    chk1("t5_ddok", s_ddok, 1'b0);
    chk1("t5_proto_pre", s_proto, 1'b0);
    mem_bus.data_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("t5_proto_held", s_proto, 1'b1);
    end

    // Reset mid-flight with three outstanding and an inst grant locked.
    mem_bus.addr_ok = 1'b1; inst_bus.req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_bus.addr = 32'h600 + 32'(4 * i);
      tick();
    end
    mem_bus.addr_ok = 1'b0; inst_bus.addr = 32'h700;
    tick();
    chk32("t6_out3", s_outst, 32'd3);
    do_reset();
    data_bus.req = 1'b1; data_bus.addr = 32'h800; mem_bus.addr_ok = 1'b1;
    tick();
    chk32("t6_out0", s_outst, 32'd0);
    chk1("t6_proto0", s_proto, 1'b0);
    chk1("t6_daok", s_daok, 1'b1);
    chk32("t6_maddr", s_maddr, 32'h800);
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (!inst_bus.req && 1'($urandom)) begin
        inst_bus.req = 1'b1; inst_bus.wr = 1'($urandom); inst_bus.size = 2'($urandom);
        inst_bus.wstrb = 4'($urandom); inst_bus.addr = $urandom; inst_bus.wdata = $urandom;
      end
      if (!data_bus.req && ($urandom % 3 == 0)) begin
        data_bus.req = 1'b1; data_bus.wr = 1'($urandom); data_bus.size = 2'($urandom);
        data_bus.wstrb = 4'($urandom); data_bus.addr = $urandom; data_bus.wdata = $urandom;
      end
      mem_bus.addr_ok = ($urandom % 3 != 0);
      mem_bus.data_ok = (mq.size() != 0) && 1'($urandom);
      mem_bus.rdata   = $urandom;
      tick();
      if (last_iacc) inst_bus.req = 1'b0;
      if (last_dacc) data_bus.req = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
